// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, fetch FSM states and
// the opcode encodings used by both the fetch front end and the decoder.
package cpu_pkg;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int FUNC_MSB   = 2;
  localparam int FUNC_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_ADDI   = 4'b0100;
  localparam logic [3:0] OP_LOAD   = 4'b1011;
  localparam logic [3:0] OP_STORE  = 4'b1111;
  localparam logic [3:0] OP_BRANCH = 4'b1000;
  localparam logic [3:0] OP_JUMP   = 4'b0010;

  // Opcode field of a 16-bit instruction word.
  function automatic logic [3:0] get_opcode(input logic [15:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  // Function field of a 16-bit instruction word.
  function automatic logic [2:0] get_func(input logic [15:0] word);
    return word[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instruction word} pairs between instruction memory and
// the decoder. Push and pop may coincide at any fill level; flush empties it.
// When empty the head outputs hold the last head presented.
module fetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_word,
  input  logic               pop,
  output logic               valid,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_word,
  output logic [CNT_W-1:0]   count
);

  logic [ADDR_W-1:0]  mem_pc_r   [DEPTH];
  logic [INSTR_W-1:0] mem_word_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [ADDR_W-1:0]  hold_pc_r;
  logic [INSTR_W-1:0] hold_word_r;
  logic               full_s;
  logic               push_eff_s;
  logic               pop_eff_s;

  assign valid      = (count_r != CNT_W'(0));
  assign full_s     = (count_r == CNT_W'(DEPTH));
  assign push_eff_s = push & ~flush;
  assign pop_eff_s  = pop & valid & ~flush;
  assign count      = count_r;

  // Entry storage: write the incoming pair at the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]   <= '0;
        mem_word_r[i] <= '0;
      end
    end else if (push_eff_s) begin
      mem_pc_r[wr_ptr_r]   <= push_pc;
      mem_word_r[wr_ptr_r] <= push_word;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_eff_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_eff_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_eff_s, pop_eff_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Remember the last presented head so outputs stay stable while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pc_r   <= '0;
      hold_word_r <= '0;
    end else if (valid) begin
      hold_pc_r   <= mem_pc_r[rd_ptr_r];
      hold_word_r <= mem_word_r[rd_ptr_r];
    end
  end

  // Head selection: live entry when valid, otherwise the held copy.
  always_comb begin
    head_pc   = hold_pc_r;
    head_word = hold_word_r;
    if (valid) begin
      head_pc   = mem_pc_r[rd_ptr_r];
      head_word = mem_word_r[rd_ptr_r];
    end else begin
      head_pc   = hold_pc_r;
      head_word = hold_word_r;
    end
  end

  fetch_queue_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .full  (full_s)
  );

endmodule

// File: rtl/fetch_queue_chk.sv
// Protocol checker for fetch_queue: a push into a full queue without a
// simultaneous pop or flush would silently lose an instruction.
module fetch_queue_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic flush,
  input logic full
);

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues reads to the synchronous
// instruction memory under a queue credit, buffers returned words and hands
// them to the decoder with opcode/func split out. A redirect flushes the
// queue, drops the in-flight return and restarts at the new PC after one
// bubble cycle.
import cpu_pkg::*;

module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [3:0]         opcode,
  output logic [2:0]         func,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  fetch_state_t       state_r;
  fetch_state_t       fsm_next_s;
  fetch_state_t       state_next_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  req_pc_r;
  logic               inflight_r;
  logic               issue_s;
  logic               fsm_issue_s;
  logic               pop_s;
  logic               push_s;
  logic               credit_s;
  logic [OCC_W-1:0]   occ_s;
  logic [CNT_W-1:0]   q_count_s;
  logic               q_valid_s;
  logic [ADDR_W-1:0]  q_pc_s;
  logic [INSTR_W-1:0] q_word_s;

  // A head accepted in the same cycle as a redirect is still consumed; the
  // flush then clears whatever remains.
  assign pop_s = q_valid_s & instr_ready;

  // The in-flight return lands this cycle; a redirect makes it stale.
  assign push_s = inflight_r & ~redirect;

  // Slots that will be occupied next cycle if nothing new is issued.
  assign occ_s    = OCC_W'(q_count_s) + OCC_W'(inflight_r) - OCC_W'(pop_s);
  assign credit_s = (occ_s < OCC_W'(DEPTH));

  // Next-state and issue decision from the current state.
  always_comb begin
    fsm_next_s  = state_r;
    fsm_issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        fsm_next_s = fetch_en ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        if (fetch_en) begin
          fsm_next_s  = ST_FETCH;
          fsm_issue_s = credit_s;
        end else begin
          fsm_next_s  = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        fsm_next_s = fetch_en ? ST_FETCH : ST_IDLE;
      end
      default: begin
        fsm_next_s = ST_IDLE;
      end
    endcase
  end

  // Redirect overrides everything: no request, go to the bubble state.
  always_comb begin
    state_next_s = redirect ? ST_FLUSH : fsm_next_s;
    issue_s      = fsm_issue_s & ~redirect;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Program counter: reload on redirect, advance (with natural wrap) on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= '0;
    end else if (redirect) begin
      pc_r <= redirect_pc;
    end else if (issue_s) begin
      pc_r <= pc_r + ADDR_W'(1);
    end
  end

  // Track the outstanding request and the address it was made for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 1'b0;
      req_pc_r   <= '0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) req_pc_r <= pc_r;
    end
  end

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push_s),
    .push_pc   (req_pc_r),
    .push_word (imem_rdata),
    .pop       (pop_s),
    .valid     (q_valid_s),
    .head_pc   (q_pc_s),
    .head_word (q_word_s),
    .count     (q_count_s)
  );

  assign imem_req    = issue_s;
  assign imem_addr   = pc_r;
  assign instr_valid = q_valid_s;
  assign instr       = q_word_s;
  assign instr_pc    = q_pc_s;
  assign opcode      = get_opcode(q_word_s);
  assign func        = get_func(q_word_s);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: a cycle-by-cycle vector table
// starting at reset release, followed by a hand-written mid-operation reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic [3:0]  opcode;
  logic [2:0]  func;
  logic        redirect;
  logic [7:0]  redirect_pc;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rd;
    logic [7:0]  rpc;
    logic        req;
    logic [7:0]  addr;
    logic        v;
    logic [15:0] word;
    logic [7:0]  pc;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .opcode      (opcode),
    .func        (func),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem[imem_addr] : 16'hDEAD;
  end

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic fe, input logic rdy, input logic rd,
                     input logic [7:0] rpc, input logic req, input logic [7:0] addr,
                     input logic v, input logic [15:0] word, input logic [7:0] pc);
    vec_t t;
    t.fe = fe; t.rdy = rdy; t.rd = rd; t.rpc = rpc; t.req = req;
    t.addr = addr; t.v = v; t.word = word; t.pc = pc;
    vecs.push_back(t);
  endtask

  task automatic chk_zero(input string name, input int cyc);
    chk({name, "_req"},   cyc, {31'd0, imem_req},    32'd0);
    chk({name, "_addr"},  cyc, {24'd0, imem_addr},   32'd0);
    chk({name, "_valid"}, cyc, {31'd0, instr_valid}, 32'd0);
    chk({name, "_instr"}, cyc, {16'd0, instr},       32'd0);
    chk({name, "_pc"},    cyc, {24'd0, instr_pc},    32'd0);
    chk({name, "_op"},    cyc, {28'd0, opcode},      32'd0);
    chk({name, "_func"},  cyc, {29'd0, func},        32'd0);
  endtask

  task automatic chk_out(input string name, input int cyc, input logic req,
                         input logic [7:0] addr, input logic v,
                         input logic [15:0] word, input logic [7:0] pc);
    logic [3:0] exp_op;
    logic [2:0] exp_fn;
    exp_op = word[15:12];
    exp_fn = word[2:0];
    chk({name, "_req"},   cyc, {31'd0, imem_req},    {31'd0, req});
    chk({name, "_addr"},  cyc, {24'd0, imem_addr},   {24'd0, addr});
    chk({name, "_valid"}, cyc, {31'd0, instr_valid}, {31'd0, v});
    if (v) begin
      chk({name, "_instr"}, cyc, {16'd0, instr},    {16'd0, word});
      chk({name, "_ipc"},   cyc, {24'd0, instr_pc}, {24'd0, pc});
      chk({name, "_op"},    cyc, {28'd0, opcode},   {28'd0, exp_op});
      chk({name, "_func"},  cyc, {29'd0, func},     {29'd0, exp_fn});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'h00, i[7:0]} ^ 16'hA500;
    mem[8'h40] = 16'hE540;
    mem[8'h10] = 16'h0005;
    mem[8'h11] = 16'h2000;

    //   fe    rdy   rd    rpc    req   addr   v     word      pc
    // ready low from the start: two words queue up, head A500 held
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00); // c0 IDLE
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00); // c1
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 16'h0000, 8'h00); // c2
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 16'hA500, 8'h00); // c3
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 16'hA500, 8'h00); // c4
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 16'hA500, 8'h00); // c5
    // ready high: one per cycle, no loss or duplicate
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 16'hA500, 8'h00); // c6
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 16'hA501, 8'h01); // c7
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 16'hA502, 8'h02); // c8
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 16'hA503, 8'h03); // c9
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 16'hA504, 8'h04); // c10
    // redirect to 0x40 with an entry queued and a return landing
    add(1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 8'h07, 1'b1, 16'hA505, 8'h05); // c11 R
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0, 16'h0000, 8'h00); // c12 bubble
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 16'h0000, 8'h00); // c13 R+2
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 16'h0000, 8'h00); // c14
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 16'hE540, 8'h40); // c15 R+4
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 16'hA541, 8'h41); // c16
    // redirect to 0xFE with accept in same cycle, then wrap
    add(1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h44, 1'b1, 16'hA542, 8'h42); // c17
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 16'h0000, 8'h00); // c18
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 16'h0000, 8'h00); // c19
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 16'h0000, 8'h00); // c20
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 16'hA5FE, 8'hFE); // c21
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 16'hA5FF, 8'hFF); // c22
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 16'hA500, 8'h00); // c23
    // redirect to 0x10: opcode/func split of 0005 and 2000
    add(1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 8'h03, 1'b1, 16'hA501, 8'h01); // c24
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0, 16'h0000, 8'h00); // c25
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 16'h0000, 8'h00); // c26
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 16'h0000, 8'h00); // c27
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 16'h0005, 8'h10); // c28
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h13, 1'b1, 16'h2000, 8'h11); // c29
    // fetch_en low: requests stop, in-flight word still delivered
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h14, 1'b1, 16'hA512, 8'h12); // c30
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h14, 1'b1, 16'hA513, 8'h13); // c31
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h14, 1'b0, 16'h0000, 8'h00); // c32
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h14, 1'b0, 16'h0000, 8'h00); // c33 IDLE
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h14, 1'b0, 16'h0000, 8'h00); // c34
    // redirect, then redirect again during the bubble: stays in FLUSH
    add(1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 8'h15, 1'b0, 16'h0000, 8'h00); // c35
    add(1'b1, 1'b1, 1'b1, 8'h90, 1'b0, 8'h80, 1'b0, 16'h0000, 8'h00); // c36
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h90, 1'b0, 16'h0000, 8'h00); // c37
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h90, 1'b0, 16'h0000, 8'h00); // c38
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h91, 1'b0, 16'h0000, 8'h00); // c39
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h92, 1'b1, 16'hA590, 8'h90); // c40

    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset", -1);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      fetch_en    = vecs[i].fe;
      instr_ready = vecs[i].rdy;
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      #1;
      chk_out("vec", i, vecs[i].req, vecs[i].addr, vecs[i].v, vecs[i].word, vecs[i].pc);
      @(posedge clk);
      #1;
    end

    // Mid-operation reset: entry queued and a return landing
    fetch_en    = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async", 41);
    @(posedge clk);
    #1;
    chk_zero("rst_edge", 42);

    // Release: fetch restarts at address 0
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk_out("restart", 0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00);
    @(posedge clk); #2;
    chk_out("restart", 1, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00);
    @(posedge clk); #2;
    chk_out("restart", 2, 1'b1, 8'h01, 1'b0, 16'h0000, 8'h00);
    @(posedge clk); #2;
    chk_out("restart", 3, 1'b1, 8'h02, 1'b1, 16'hA500, 8'h00);
    @(posedge clk); #2;
    chk_out("restart", 4, 1'b1, 8'h03, 1'b1, 16'hA501, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
